// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet transmit path.
//   CRC32_POLY_REFL : reflected IEEE 802.3 CRC-32 polynomial
//   CRC32_INIT      : CRC register value loaded at each SFD
//   CRC32_RESIDUE   : register value left after folding data plus a good FCS
//   PREAMBLE_BYTE   : preamble byte value
//   SFD_BYTE        : start-of-frame delimiter value
//   tx_state_t      : framer state; it names the byte currently on tx_data
package eth_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;

    typedef enum logic [3:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG,
        ERR,
        DROP
    } tx_state_t;

endpackage

// File: rtl/eth_tx_framer_if.sv
// Upstream byte stream into the transmit framer.
//   s_data  : frame byte (DA..payload)
//   s_valid : s_data / s_last are meaningful this cycle
//   s_last  : s_data is the final byte of the frame
//   s_ready : the framer takes the byte this cycle
// Handshake: a byte transfers on a rising clk edge where s_valid and s_ready
// are both 1. s_ready depends only on framer state, never on s_valid.
// Once s_valid is raised the source holds s_data/s_last stable until the
// transfer; dropping s_valid in the middle of a frame aborts that frame.
interface eth_tx_framer_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/eth_crc32_byte.sv
// One byte step of the reflected IEEE 802.3 CRC-32, purely combinational.
// Bits are folded LSB first. Shared with the receive-side FCS checker.
//   crc_in  : current CRC register
//   data    : byte to fold in
//   crc_out : CRC register after the byte
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Byte-wide Ethernet MAC transmit framer (MII byte side).
// Takes DA..payload bytes from upstream and sends preamble, SFD, data, zero
// pad up to MIN_FRAME_BYTES, the FCS (LSB byte first) and the inter-frame gap.
// An upstream underflow mid-frame is marked with one tx_er byte and the rest
// of that frame is swallowed.
//   clk, reset_n : clock, asynchronous active-low reset
//   s            : upstream byte stream (slave side)
//   tx_data      : transmit byte (registered)
//   tx_en        : transmit enable (registered)
//   tx_er        : transmit error, high only in ERR (registered)
//   busy         : framer is not IDLE
//   state_o      : current state, for observation
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_BYTES  = 7,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int IFG_BYTES       = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    eth_tx_framer_if.slave        s,
    output logic [7:0]            tx_data,
    output logic                  tx_en,
    output logic                  tx_er,
    output logic                  busy,
    output tx_state_t             state_o
);

    localparam logic [15:0] PRE_N = 16'(PREAMBLE_BYTES);
    localparam logic [15:0] MIN_N = 16'(MIN_FRAME_BYTES);
    localparam logic [15:0] IFG_N = 16'(IFG_BYTES);
    localparam logic [15:0] FCS_N = 16'd4;

    tx_state_t   state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic [15:0] cnt_q, cnt_d;    // frame bytes (data + pad) placed on the wire
    logic [15:0] ph_q, ph_d;      // position within PRE / FCS / IFG runs
    logic [31:0] crc_q, crc_d;
    logic        last_q, last_d;  // s_last already taken for this frame

    logic        accept;
    logic [7:0]  crc_byte;
    logic [31:0] crc_next;
    logic [31:0] fcs;
    logic [15:0] cnt_inc;

    assign s.s_ready = (state_q == SFD) || (state_q == DROP) ||
                       ((state_q == DATA) && !last_q);
    assign accept    = s.s_valid && s.s_ready;

    // Pad bytes are zero, so the same CRC step serves both data and pad.
    assign crc_byte  = accept ? s.s_data : 8'h00;
    assign fcs       = ~crc_q;
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    eth_crc32_byte u_crc (
        .crc_in  (crc_q),
        .data    (crc_byte),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d   = state_q;
        tx_data_d = 8'h00;
        tx_en_d   = 1'b0;
        tx_er_d   = 1'b0;
        cnt_d     = cnt_q;
        ph_d      = ph_q;
        crc_d     = crc_q;
        last_d    = last_q;

        case (state_q)
            IDLE: begin
                if (s.s_valid) begin
                    state_d   = PRE;
                    ph_d      = 16'd1;
                    tx_data_d = PREAMBLE_BYTE;
                    tx_en_d   = 1'b1;
                end
            end

            PRE: begin
                tx_en_d = 1'b1;
                if (ph_q < PRE_N) begin
                    ph_d      = ph_q + 16'd1;
                    tx_data_d = PREAMBLE_BYTE;
                end else begin
                    state_d   = SFD;
                    tx_data_d = SFD_BYTE;
                    crc_d     = CRC32_INIT;
                    cnt_d     = 16'd0;
                    last_d    = 1'b0;
                end
            end

            SFD, DATA, PAD: begin
                tx_en_d = 1'b1;
                if (state_q == PAD || last_q) begin
                    // Frame body complete: pad to minimum length, then FCS.
                    if (cnt_q < MIN_N) begin
                        state_d = PAD;
                        crc_d   = crc_next;
                        cnt_d   = cnt_inc;
                    end else begin
                        state_d   = FCS;
                        ph_d      = 16'd1;
                        tx_data_d = fcs[7:0];
                    end
                end else if (s.s_valid) begin
                    state_d   = DATA;
                    tx_data_d = s.s_data;
                    crc_d     = crc_next;
                    cnt_d     = cnt_inc;
                    last_d    = s.s_last;
                end else begin
                    // Upstream ran dry before s_last.
                    state_d = ERR;
                    tx_er_d = 1'b1;
                end
            end

            FCS: begin
                if (ph_q < FCS_N) begin
                    ph_d      = ph_q + 16'd1;
                    tx_en_d   = 1'b1;
                    tx_data_d = fcs[{ph_q[1:0], 3'b000} +: 8];
                end else begin
                    state_d = IFG;
                    ph_d    = 16'd1;
                end
            end

            IFG: begin
                if (ph_q < IFG_N) begin
                    ph_d = ph_q + 16'd1;
                end else begin
                    state_d = IDLE;
                end
            end

            ERR: begin
                state_d = DROP;
            end

            DROP: begin
                if (accept && s.s_last) begin
                    state_d = IFG;
                    ph_d    = 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
            tx_er_q   <= 1'b0;
            cnt_q     <= 16'd0;
            ph_q      <= 16'd0;
            crc_q     <= CRC32_INIT;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            tx_er_q   <= tx_er_d;
            cnt_q     <= cnt_d;
            ph_q      <= ph_d;
            crc_q     <= crc_d;
            last_q    <= last_d;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_en   = tx_en_q;
    assign tx_er   = tx_er_q;
    assign busy    = (state_q != IDLE);
    assign state_o = state_q;

endmodule
